muldiv_engine: RTL and testbench

MULDIV_ENGINE -- requirements
Module: muldiv_engine

---
 rtl/muldiv_engine.sv | 182 ++++++++++++++++++
 tb/tb_muldiv_engine.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_engine.sv
// muldiv_engine: HI/LO multiply/divide unit with fixed-latency busy window.
//
// Ports:
//   clk     - clock, all state changes on the rising edge
//   reset   - asynchronous, active-low reset
//   start   - request strobe; op/a/b sampled on the accepting edge (only when idle)
//   op      - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB
//   a, b    - operands (a is also the MTHI/MTLO source)
//   rd_sel  - rdata select, 0 = LO, 1 = HI
//   busy    - high while an arithmetic op is in flight
//   done    - one-cycle pulse after HI/LO take a new arithmetic result
//   hi, lo  - current HI/LO registers
//   rdata   - combinational HI/LO read mux
//
// Optional feature: define MULDIV_MADD_EN to enable MADD/MSUB accumulation into
// {HI,LO}. Without it, op 110/111 is accepted as a no-op and no accumulator is built.
//
// The result is computed combinationally from the latched operands and written
// when the countdown expires; the countdown alone sets the visible latency.
module muldiv_engine #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rdata
);

    localparam int unsigned DW = 2 * WIDTH;
    localparam logic [4:0] MulCnt = 5'(MUL_CYCLES);
    localparam logic [4:0] DivCnt = 5'(DIV_CYCLES);

    typedef enum logic [2:0] {
        OpMult  = 3'b000,
        OpMultu = 3'b001,
        OpDiv   = 3'b010,
        OpDivu  = 3'b011,
        OpMthi  = 3'b100,
        OpMtlo  = 3'b101,
        OpMadd  = 3'b110,
        OpMsub  = 3'b111
    } op_e;

    typedef enum logic {StIdle, StBusy} state_e;

    state_e           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;

    // Arithmetic datapath on the latched operands
    logic signed [DW-1:0] a_sx, b_sx, prod_s;
    logic [DW-1:0]        prod_u, res;
    logic                 neg_a, neg_b;
    logic [WIDTH-1:0]     mag_a, mag_b, uq, ur, quo, rem;

    always_comb begin
        a_sx   = {{WIDTH{a_q[WIDTH-1]}}, a_q};
        b_sx   = {{WIDTH{b_q[WIDTH-1]}}, b_q};
        prod_s = a_sx * b_sx;
        prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

        // Signed divide via magnitudes: the most-negative / -1 case falls out as
        // quotient = a, remainder = 0 without overflowing.
        neg_a = (op_q == OpDiv) && a_q[WIDTH-1];
        neg_b = (op_q == OpDiv) && b_q[WIDTH-1];
        mag_a = neg_a ? -a_q : a_q;
        mag_b = neg_b ? -b_q : b_q;
        uq    = mag_a / mag_b;
        ur    = mag_a % mag_b;
        if (b_q == '0) begin
            quo = '1;
            rem = a_q;
        end else begin
            quo = (neg_a ^ neg_b) ? -uq : uq;
            rem = neg_a ? -ur : ur;
        end

        unique case (op_q)
            OpMult:        res = prod_s;
            OpMultu:       res = prod_u;
            OpDiv, OpDivu: res = {rem, quo};
`ifdef MULDIV_MADD_EN
            OpMadd:        res = {hi_q, lo_q} + prod_s;
            OpMsub:        res = {hi_q, lo_q} - prod_s;
`endif
            default:       res = {hi_q, lo_q};
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_d = op_e'(op);
                    a_d  = a;
                    b_d  = b;
                    unique case (op_e'(op))
                        OpMult, OpMultu: begin
                            state_d = StBusy;
                            cnt_d   = MulCnt;
                        end
                        OpDiv, OpDivu: begin
                            state_d = StBusy;
                            cnt_d   = DivCnt;
                        end
                        OpMthi: hi_d = a;
                        OpMtlo: lo_d = a;
`ifdef MULDIV_MADD_EN
                        OpMadd, OpMsub: begin
                            state_d = StBusy;
                            cnt_d   = MulCnt;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            StBusy: begin
                if (cnt_q == 5'd1) begin
                    {hi_d, lo_d} = res;
                    done_d       = 1'b1;
                    state_d      = StIdle;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= OpMult;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy  = (state_q == StBusy);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign rdata = rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_engine.sv
// Self-checking bench for muldiv_engine (WIDTH=32, MUL_CYCLES=5, DIV_CYCLES=10).
// Expected HI/LO pairs are queued when an arithmetic op is issued and popped when
// done is seen. Inputs change and outputs are sampled on the falling edge.
module tb_muldiv_engine;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;
    localparam logic [2:0] OpMadd  = 3'b110;
    localparam logic [2:0] OpMsub  = 3'b111;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         rd_sel = 1'b0;
    logic         busy, done;
    logic [W-1:0] hi, lo, rdata;

    muldiv_engine #(
        .WIDTH(W),
        .MUL_CYCLES(MC),
        .DIV_CYCLES(DC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .a(a),
        .b(b),
        .rd_sel(rd_sel),
        .busy(busy),
        .done(done),
        .hi(hi),
        .lo(lo),
        .rdata(rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_fail = 0;
    logic [W-1:0] pre_hi, pre_lo;

    // Drive one request for one cycle; returns on the next falling edge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        pre_hi = hi;
        pre_lo = lo;
        start  = 1'b1;
        op     = o;
        a      = x;
        b      = y;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Count the busy window, then check done and the popped expectation.
    task automatic finish_op(input string name, input int exp_cycles, input int already,
                             input bit check_drop);
        int   n;
        bit   held;
        exp_t e;
        n    = already;
        held = 1'b1;
        while (busy === 1'b1 && n < 200) begin
            n++;
            if (hi !== pre_hi || lo !== pre_lo) held = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (n != exp_cycles) begin
            n_fail++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, n, exp_cycles);
        end
        n_checks++;
        if (held !== 1'b1) begin
            n_fail++;
            $display("FAIL %s hold: hi/lo changed during busy (got 0 expected 1)", name);
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done_pulse: got %b expected 1", name, done);
        end
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s scoreboard: got empty queue expected an entry", name);
        end else begin
            e = sb.pop_front();
            if (hi !== e.hi || lo !== e.lo) begin
                n_fail++;
                $display("FAIL %s result: got hi=%h lo=%h expected hi=%h lo=%h",
                         name, hi, lo, e.hi, e.lo);
            end
            rd_sel = 1'b1;
            #1;
            n_checks++;
            if (rdata !== e.hi) begin
                n_fail++;
                $display("FAIL %s rdata_hi: got %h expected %h", name, rdata, e.hi);
            end
            rd_sel = 1'b0;
            #1;
            n_checks++;
            if (rdata !== e.lo) begin
                n_fail++;
                $display("FAIL %s rdata_lo: got %h expected %h", name, rdata, e.lo);
            end
        end
        if (check_drop) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s done_drop: got %b expected 0", name, done);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        // start during reset must be ignored
        start = 1'b1;
        op    = OpMthi;
        a     = 32'hAAAA_5555;
        @(negedge clk);
        n_checks++;
        if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b expected all 0",
                     hi, lo, busy, done);
        end
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (hi !== '0) begin
            n_fail++;
            $display("FAIL reset_start_ignored: got hi=%h expected 0", hi);
        end
    endtask

    task automatic test_mthi_mtlo();
        start = 1'b1;
        op    = OpMthi;
        a     = 32'h1111_2222;
        @(negedge clk);
        n_checks++;
        if (hi !== 32'h1111_2222 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL mthi: got hi=%h busy=%b done=%b expected 11112222 0 0",
                     hi, busy, done);
        end
        op = OpMtlo;
        a  = 32'h3333_4444;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (lo !== 32'h3333_4444 || hi !== 32'h1111_2222 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mtlo_b2b: got hi=%h lo=%h busy=%b expected 11112222 33334444 0",
                     hi, lo, busy);
        end
    endtask

    task automatic test_directed();
        sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFA});
        issue(OpMult, 32'hFFFF_FFFE, 32'd3);
        finish_op("mult_neg", MC, 0, 1'b1);
        sb.push_back('{32'h0000_0001, 32'hFFFF_FFFE});
        issue(OpMultu, 32'hFFFF_FFFF, 32'd2);
        finish_op("multu", MC, 0, 1'b1);
        sb.push_back('{32'd1, 32'd3});
        issue(OpDivu, 32'd7, 32'd2);
        finish_op("divu", DC, 0, 1'b1);
        sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFD});
        issue(OpDiv, 32'hFFFF_FFF9, 32'd2);
        finish_op("div_neg", DC, 0, 1'b1);
        sb.push_back('{32'd5, 32'hFFFF_FFFF});
        issue(OpDiv, 32'd5, 32'd0);
        finish_op("div_zero", DC, 0, 1'b1);
        sb.push_back('{32'd0, 32'h8000_0000});
        issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("div_ovf", DC, 0, 1'b1);
        sb.push_back('{32'd9, 32'hFFFF_FFFF});
        issue(OpDivu, 32'd9, 32'd0);
        finish_op("divu_zero", DC, 0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0]   x, y;
            logic [2:0]     o;
            logic [2*W-1:0] p;
            longint         sx, sy, q, r;
            x = $urandom();
            y = $urandom();
            o = 3'($urandom_range(0, 3));
            if (o == OpDiv || o == OpDivu) y = y | 32'h1;
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            case (o)
                OpMult:  p = 64'(sx * sy);
                OpMultu: p = {32'h0, x} * {32'h0, y};
                OpDiv: begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {32'(r), 32'(q)};
                end
                default: p = {x % y, x / y};
            endcase
            sb.push_back('{p[2*W-1:W], p[W-1:0]});
            issue(o, x, y);
            finish_op($sformatf("rand%0d_op%0d", i, o), (o[1] ? DC : MC), 0, 1'b1);
        end
    endtask

    task automatic test_busy_ignore();
        issue(OpMthi, 32'h1234_5678, 32'h0);
        n_checks++;
        if (hi !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL busy_ign_mthi: got hi=%h expected 12345678", hi);
        end
        sb.push_back('{32'd2, 32'd14});
        issue(OpDiv, 32'd100, 32'd7);
        @(negedge clk);
        // New request mid-window, plus operand changes: must be ignored.
        start = 1'b1;
        op    = OpMthi;
        a     = 32'hDEAD_BEEF;
        b     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        op    = OpMult;
        a     = 32'd50;
        b     = 32'd0;
        finish_op("busy_ignore", DC, 2, 1'b1);
    endtask

    task automatic test_back_to_back();
        sb.push_back('{32'd0, 32'd42});
        issue(OpMult, 32'd6, 32'd7);
        finish_op("b2b_first", MC, 0, 1'b0);
        sb.push_back('{32'd1, 32'd0});
        issue(OpMultu, 32'h0001_0000, 32'h0001_0000);
        finish_op("b2b_second", MC, 0, 1'b1);
    endtask

    task automatic test_abort();
        bit saw_done;
        bit stayed_zero;
        issue(OpMthi, 32'h55, 32'h0);
        issue(OpMtlo, 32'h66, 32'h0);
        issue(OpMult, 32'd3, 32'd4);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_reset: got hi=%h lo=%h busy=%b done=%b expected 0 0 0 0",
                     hi, lo, busy, done);
        end
        @(negedge clk);
        reset = 1'b1;
        saw_done    = 1'b0;
        stayed_zero = 1'b1;
        for (int i = 0; i < 2 * MC; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
            if (hi !== '0 || lo !== '0) stayed_zero = 1'b0;
        end
        n_checks++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: got done/busy activity 1 expected 0");
        end
        n_checks++;
        if (stayed_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_no_write: got hi=%h lo=%h expected 0 0", hi, lo);
        end
    endtask

    task automatic test_madd();
        issue(OpMthi, 32'd0, 32'd0);
        issue(OpMtlo, 32'd10, 32'd0);
`ifdef MULDIV_MADD_EN
        sb.push_back('{32'd0, 32'd22});
        issue(OpMadd, 32'd3, 32'd4);
        finish_op("madd", MC, 0, 1'b1);
        sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFD});
        issue(OpMsub, 32'd5, 32'd5);
        finish_op("msub", MC, 0, 1'b1);
`else
        begin
            bit activity;
            activity = 1'b0;
            issue(OpMadd, 32'd3, 32'd4);
            issue(OpMsub, 32'd5, 32'd5);
            for (int i = 0; i < MC + 2; i++) begin
                if (busy === 1'b1 || done === 1'b1) activity = 1'b1;
                @(negedge clk);
            end
            n_checks++;
            if (activity !== 1'b0) begin
                n_fail++;
                $display("FAIL madd_noop_idle: got busy/done activity 1 expected 0");
            end
            n_checks++;
            if (hi !== 32'd0 || lo !== 32'd10) begin
                n_fail++;
                $display("FAIL madd_noop_regs: got hi=%h lo=%h expected 0 a", hi, lo);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_mthi_mtlo();
        test_directed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_abort();
        test_madd();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
